// File: rtl/xbar_pkg.sv
// Shared types and helpers for the streaming crossbar connection scheduler.
// Latency: none (types, constants and a combinational pick function only).
// Backpressure: not applicable.
package xbar_pkg;

    // Default crossbar geometry; the modules take these as parameter defaults
    localparam int unsigned XBAR_S_DATA_COUNT = 5;
    localparam int unsigned XBAR_M_DATA_COUNT = 3;
    localparam int unsigned XBAR_ID_WIDTH     = $clog2(XBAR_S_DATA_COUNT);
    localparam int unsigned XBAR_DEST_WIDTH   = $clog2(XBAR_M_DATA_COUNT);

    // Widest request vector the pick function scans
    localparam int unsigned XBAR_MAX_S = 32;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } port_state_t;

    // First set bit of req[n-1:0], scanning upward from start and wrapping to 0.
    // The wrap is an explicit compare-and-reset so no modulo hardware is built.
    function automatic int unsigned rr_pick(input logic [XBAR_MAX_S-1:0] req,
                                            input int unsigned           n,
                                            input int unsigned           start);
        int unsigned idx;
        int unsigned pick;
        logic        found;
        idx   = start;
        pick  = 0;
        found = 1'b0;
        for (int unsigned i = 0; i < XBAR_MAX_S; i++) begin
            if (i < n) begin
                if (!found && req[idx]) begin
                    pick  = idx;
                    found = 1'b1;
                end
                if (idx == n - 1) idx = 0;
                else              idx = idx + 1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/xbar_port_sched.sv
// One output's connection scheduler: round-robin grant, held until the last beat transfers.
// Latency: grant registers one edge after a request is seen; handshakes are combinational in BUSY.
// Backpressure: m_ready low stalls the held input via its one-hot s_ready contribution.
module xbar_port_sched
    import xbar_pkg::*;
#(
    parameter int S_DATA_COUNT = XBAR_S_DATA_COUNT,
    parameter int T_ID___WIDTH = XBAR_ID_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [S_DATA_COUNT-1:0] req,
    input  logic [S_DATA_COUNT-1:0] s_valid_i,
    input  logic [S_DATA_COUNT-1:0] s_last_i,
    input  logic                    m_ready_i,
    output logic                    m_valid_o,
    output logic                    m_last_o,
    output logic [T_ID___WIDTH-1:0] m_id_o,
    output logic                    busy_o,
    output logic [T_ID___WIDTH-1:0] grant_o,
    output logic [S_DATA_COUNT-1:0] s_ready_o
);

    port_state_t             state_q, state_d;
    logic [T_ID___WIDTH-1:0] grant_q, grant_d;
    logic [T_ID___WIDTH-1:0] ptr_q, ptr_d;

    // State, grant and search pointer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    // Arbitration in IDLE; handshake steering and end-of-packet release in BUSY
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        m_valid_o = 1'b0;
        m_last_o  = 1'b0;
        m_id_o    = '0;
        s_ready_o = '0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_d = T_ID___WIDTH'(rr_pick(XBAR_MAX_S'(req), S_DATA_COUNT, int'(ptr_q)));
                    state_d = BUSY;
                end
            end
            BUSY: begin
                m_valid_o          = s_valid_i[grant_q];
                m_last_o           = s_last_i[grant_q];
                m_id_o             = grant_q;
                s_ready_o[grant_q] = m_ready_i;
                if (s_valid_i[grant_q] && m_ready_i && s_last_i[grant_q]) begin
                    state_d = IDLE;
                    ptr_d   = (grant_q == T_ID___WIDTH'(S_DATA_COUNT - 1)) ? '0 : grant_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o  = (state_q == BUSY);
    assign grant_o = grant_q;

endmodule

// File: rtl/stream_xbar_sched.sv
// Crossbar connection scheduler: decodes destinations, masks held inputs, arbitrates per output.
// Latency: one idle arbitration cycle per packet per output; handshakes combinational once held.
// Backpressure: s_ready of a held input follows its output's m_ready; invalid destinations are sunk.
module stream_xbar_sched
    import xbar_pkg::*;
#(
    parameter int S_DATA_COUNT = XBAR_S_DATA_COUNT,
    parameter int M_DATA_COUNT = XBAR_M_DATA_COUNT,
    parameter int T_ID___WIDTH = $clog2(S_DATA_COUNT),
    parameter int T_DEST_WIDTH = $clog2(M_DATA_COUNT)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [S_DATA_COUNT-1:0]              s_valid_i,
    input  logic [S_DATA_COUNT-1:0]              s_last_i,
    input  logic [S_DATA_COUNT*T_DEST_WIDTH-1:0] s_dest_i,
    output logic [S_DATA_COUNT-1:0]              s_ready_o,
    input  logic [M_DATA_COUNT-1:0]              m_ready_i,
    output logic [M_DATA_COUNT-1:0]              m_valid_o,
    output logic [M_DATA_COUNT-1:0]              m_last_o,
    output logic [M_DATA_COUNT*T_ID___WIDTH-1:0] m_id_o
);

    logic [S_DATA_COUNT-1:0] req      [M_DATA_COUNT];
    logic [S_DATA_COUNT-1:0] rdy_part [M_DATA_COUNT];
    logic [T_ID___WIDTH-1:0] grant    [M_DATA_COUNT];
    logic [M_DATA_COUNT-1:0] busy;
    logic [S_DATA_COUNT-1:0] held;
    logic [S_DATA_COUNT-1:0] sink;
    logic [T_DEST_WIDTH-1:0] dest;

    // An input is held while any BUSY output has it as its grant
    always_comb begin
        held = '0;
        for (int m = 0; m < M_DATA_COUNT; m++) begin
            for (int s = 0; s < S_DATA_COUNT; s++) begin
                if (busy[m] && grant[m] == T_ID___WIDTH'(s)) held[s] = 1'b1;
            end
        end
    end

    // Destination decode into per-output requests; free inputs with bad destinations are sunk
    always_comb begin
        dest = '0;
        sink = '0;
        for (int m = 0; m < M_DATA_COUNT; m++) req[m] = '0;
        for (int s = 0; s < S_DATA_COUNT; s++) begin
            dest = s_dest_i[s*T_DEST_WIDTH +: T_DEST_WIDTH];
            if (s_valid_i[s] && !held[s]) begin
                if (int'(dest) >= M_DATA_COUNT) begin
                    sink[s] = 1'b1;
                end else begin
                    for (int m = 0; m < M_DATA_COUNT; m++) begin
                        if (dest == T_DEST_WIDTH'(m)) req[m][s] = 1'b1;
                    end
                end
            end
        end
    end

    // Each input has at most one holder, so OR-ing the one-hot contributions is safe
    always_comb begin
        s_ready_o = sink;
        for (int m = 0; m < M_DATA_COUNT; m++) s_ready_o = s_ready_o | rdy_part[m];
    end

    for (genvar m = 0; m < M_DATA_COUNT; m++) begin : g_port
        xbar_port_sched #(
            .S_DATA_COUNT (S_DATA_COUNT),
            .T_ID___WIDTH (T_ID___WIDTH)
        ) u_port (
            .clk       (clk),
            .rst       (rst),
            .req       (req[m]),
            .s_valid_i (s_valid_i),
            .s_last_i  (s_last_i),
            .m_ready_i (m_ready_i[m]),
            .m_valid_o (m_valid_o[m]),
            .m_last_o  (m_last_o[m]),
            .m_id_o    (m_id_o[m*T_ID___WIDTH +: T_ID___WIDTH]),
            .busy_o    (busy[m]),
            .grant_o   (grant[m]),
            .s_ready_o (rdy_part[m])
        );
    end

endmodule

// File: tb/tb_stream_xbar_sched.sv
// Directed bench for stream_xbar_sched with hand-computed expectations.
// Latency: inputs change 1 time unit after the rising edge, outputs are sampled on the falling edge.
// Backpressure: exercised by dropping m_ready_i mid-packet.
module tb_stream_xbar_sched;

    logic       clk;
    logic       rst;
    logic [4:0] s_valid_i;
    logic [4:0] s_last_i;
    logic [9:0] s_dest_i;
    logic [4:0] s_ready_o;
    logic [2:0] m_ready_i;
    logic [2:0] m_valid_o;
    logic [2:0] m_last_o;
    logic [8:0] m_id_o;

    logic [1:0] dst [5];
    int         vec_cnt = 0;
    int         err_cnt = 0;
    int         order [6] = '{0, 1, 4, 0, 1, 4};

    assign s_dest_i = {dst[4], dst[3], dst[2], dst[1], dst[0]};

    stream_xbar_sched dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid_i (s_valid_i),
        .s_last_i  (s_last_i),
        .s_dest_i  (s_dest_i),
        .s_ready_o (s_ready_o),
        .m_ready_i (m_ready_i),
        .m_valid_o (m_valid_o),
        .m_last_o  (m_last_o),
        .m_id_o    (m_id_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        s_valid_i = '0;
        s_last_i  = '0;
        m_ready_i = 3'b111;
        for (int i = 0; i < 5; i++) dst[i] = 2'd0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        @(negedge clk);
        check_vec("rst_valid", 32'(m_valid_o), 32'h0);
        check_vec("rst_last",  32'(m_last_o),  32'h0);
        check_vec("rst_id",    32'(m_id_o),    32'h0);
        check_vec("rst_ready", 32'(s_ready_o), 32'h0);
        rst = 1'b0;
        next_cycle();

        // Single 3-beat packet: input 2 -> output 1
        s_valid_i = 5'b00100;
        dst[2]    = 2'd1;
        @(negedge clk);
        check_vec("t1_arb_valid", 32'(m_valid_o), 32'h0);
        check_vec("t1_arb_ready", 32'(s_ready_o), 32'h0);
        next_cycle();
        for (int b = 0; b < 3; b++) begin
            s_last_i = (b == 2) ? 5'b00100 : 5'b00000;
            @(negedge clk);
            check_vec("t1_valid", 32'(m_valid_o),    32'h2);
            check_vec("t1_id1",   32'(m_id_o[5:3]),  32'h2);
            check_vec("t1_ready", 32'(s_ready_o),    32'h4);
            check_vec("t1_last",  32'(m_last_o),     (b == 2) ? 32'h2 : 32'h0);
            next_cycle();
        end
        s_valid_i = '0;
        s_last_i  = '0;
        @(negedge clk);
        check_vec("t1_idle_valid", 32'(m_valid_o), 32'h0);
        check_vec("t1_idle_id",    32'(m_id_o),    32'h0);
        next_cycle();

        // Contention: inputs 0, 1, 4 send single-beat packets to output 0
        s_valid_i = 5'b10011;
        s_last_i  = 5'b10011;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c % 2 == 1) begin
                check_vec("t2_valid", 32'(m_valid_o),   32'h1);
                check_vec("t2_id0",   32'(m_id_o[2:0]), 32'(order[c/2]));
                check_vec("t2_ready", 32'(s_ready_o),   32'(1) << order[c/2]);
            end else begin
                check_vec("t2_arb_valid", 32'(m_valid_o), 32'h0);
                check_vec("t2_arb_ready", 32'(s_ready_o), 32'h0);
            end
            next_cycle();
        end
        s_valid_i = '0;
        s_last_i  = '0;

        // Parallel: input 0 -> output 0, input 3 -> output 2
        s_valid_i = 5'b01001;
        s_last_i  = 5'b01001;
        dst[0]    = 2'd0;
        dst[3]    = 2'd2;
        @(negedge clk);
        check_vec("t3_arb_valid", 32'(m_valid_o), 32'h0);
        next_cycle();
        @(negedge clk);
        check_vec("t3_valid", 32'(m_valid_o), 32'h5);
        check_vec("t3_id",    32'(m_id_o),    32'h0C0);
        check_vec("t3_ready", 32'(s_ready_o), 32'h09);
        next_cycle();
        s_valid_i = '0;
        s_last_i  = '0;
        @(negedge clk);
        check_vec("t3_idle_valid", 32'(m_valid_o), 32'h0);
        next_cycle();

        // Backpressure: input 2 -> output 1, 4 beats, m_ready_i[1] low after beat 1
        s_valid_i = 5'b00100;
        dst[2]    = 2'd1;
        @(negedge clk);
        check_vec("t4_arb_valid", 32'(m_valid_o), 32'h0);
        next_cycle();
        @(negedge clk);
        check_vec("t4_b1_valid", 32'(m_valid_o), 32'h2);
        check_vec("t4_b1_ready", 32'(s_ready_o), 32'h4);
        next_cycle();
        m_ready_i = 3'b101;
        dst[2]    = 2'd0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_vec("t4_stall_ready", 32'(s_ready_o), 32'h0);
            check_vec("t4_stall_valid", 32'(m_valid_o), 32'h2);
            check_vec("t4_stall_id",    32'(m_id_o),    32'h010);
            next_cycle();
        end
        m_ready_i = 3'b111;
        for (int b = 2; b <= 4; b++) begin
            s_last_i = (b == 4) ? 5'b00100 : 5'b00000;
            @(negedge clk);
            check_vec("t4_valid", 32'(m_valid_o),   32'h2);
            check_vec("t4_id1",   32'(m_id_o[5:3]), 32'h2);
            check_vec("t4_ready", 32'(s_ready_o),   32'h4);
            check_vec("t4_last",  32'(m_last_o),    (b == 4) ? 32'h2 : 32'h0);
            next_cycle();
        end
        s_valid_i = '0;
        s_last_i  = '0;
        dst[2]    = 2'd1;
        @(negedge clk);
        check_vec("t4_idle_valid", 32'(m_valid_o), 32'h0);
        next_cycle();

        // Reset mid-packet: input 1 -> output 2; afterwards inputs 1 and 4 contend
        s_valid_i = 5'b00010;
        dst[1]    = 2'd2;
        @(negedge clk);
        check_vec("t5_arb_valid", 32'(m_valid_o), 32'h0);
        next_cycle();
        @(negedge clk);
        check_vec("t5_b1_valid", 32'(m_valid_o),   32'h4);
        check_vec("t5_b1_id2",   32'(m_id_o[8:6]), 32'h1);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        check_vec("t5_b2_valid", 32'(m_valid_o), 32'h4);
        check_vec("t5_b2_ready", 32'(s_ready_o), 32'h2);
        next_cycle();
        rst       = 1'b0;
        s_valid_i = 5'b10010;
        s_last_i  = 5'b10010;
        dst[4]    = 2'd2;
        @(negedge clk);
        check_vec("t5_post_valid", 32'(m_valid_o), 32'h0);
        check_vec("t5_post_last",  32'(m_last_o),  32'h0);
        check_vec("t5_post_ready", 32'(s_ready_o), 32'h0);
        check_vec("t5_post_id",    32'(m_id_o),    32'h0);
        next_cycle();
        @(negedge clk);
        check_vec("t5_regrant_id2",   32'(m_id_o[8:6]), 32'h1);
        check_vec("t5_regrant_valid", 32'(m_valid_o),   32'h4);
        check_vec("t5_regrant_last",  32'(m_last_o),    32'h4);
        check_vec("t5_regrant_ready", 32'(s_ready_o),   32'h02);
        next_cycle();
        s_valid_i = 5'b10000;
        @(negedge clk);
        check_vec("t5_arb2_valid", 32'(m_valid_o), 32'h0);
        next_cycle();
        @(negedge clk);
        check_vec("t5_next_id2",   32'(m_id_o[8:6]), 32'h4);
        check_vec("t5_next_ready", 32'(s_ready_o),   32'h10);
        next_cycle();
        s_valid_i = '0;
        s_last_i  = '0;

        // Invalid destination: input 1 -> dest 3 is sunk
        s_valid_i = 5'b00010;
        dst[1]    = 2'd3;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_vec("t6_sink_ready", 32'(s_ready_o), 32'h2);
            check_vec("t6_sink_valid", 32'(m_valid_o), 32'h0);
            next_cycle();
        end
        s_valid_i = '0;
        @(negedge clk);
        check_vec("t6_quiet_ready", 32'(s_ready_o), 32'h0);
        next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
